// File: rtl/palette_lut.sv
// Banked colour look-up table with a shadow copy committed at frame_start and a global fade.
// Index in, faded 24-bit RGB out two cycles later at one pixel per cycle.
module palette_lut #(
  parameter int INDEX_W = 4,
  parameter int BANKS   = 4,
  parameter int COLOR_W = 8,
  parameter int FADE_W  = 3,
  localparam int BANK_W = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   pix_valid,
  input  logic [BANK_W-1:0]      pix_bank,
  input  logic [INDEX_W-1:0]     pix_index,
  output logic                   rgb_valid,
  output logic [COLOR_W-1:0]     r,
  output logic [COLOR_W-1:0]     g,
  output logic [COLOR_W-1:0]     b,
  input  logic                   wr_en,
  input  logic [BANK_W-1:0]      wr_bank,
  input  logic [INDEX_W-1:0]     wr_index,
  input  logic [3*COLOR_W-1:0]   wr_rgb,
  input  logic                   commit_req,
  input  logic                   frame_start,
  input  logic [FADE_W-1:0]      fade_level,
  output logic                   commit_pending
);

  localparam int ENTRIES = 2 ** INDEX_W;
  localparam int RGB_W   = 3 * COLOR_W;
  localparam int PROD_W  = COLOR_W + FADE_W + 1;
  localparam logic [BANK_W:0] BANK_LIMIT = (BANK_W + 1)'(BANKS);

  // Power-on palette; channels are resized keeping the LSBs when COLOR_W differs from 8.
  function automatic logic [RGB_W-1:0] defaultEntry(input int idx);
    logic [23:0] v;
    case (idx)
      0:       v = {8'd0,   8'd0,   8'd1};
      1:       v = {8'd99,  8'd99,  8'd99};
      2:       v = {8'd107, 8'd8,   8'd0};
      3:       v = {8'd156, 8'd74,  8'd0};
      4:       v = {8'd173, 8'd173, 8'd173};
      5:       v = {8'd255, 8'd255, 8'd255};
      6:       v = {8'd90,  8'd0,   8'd123};
      7:       v = {8'd181, 8'd49,  8'd33};
      8:       v = {8'd0,   8'd66,  8'd74};
      9:       v = {8'd231, 8'd231, 8'd148};
      10:      v = {8'd107, 8'd107, 8'd0};
      11:      v = {8'd231, 8'd156, 8'd33};
      12:      v = {8'd181, 8'd247, 8'd206};
      13:      v = {8'd0,   8'd82,  8'd0};
      14:      v = {8'd0,   8'd140, 8'd49};
      default: v = 24'd0;
    endcase
    return {COLOR_W'(v[23:16]), COLOR_W'(v[15:8]), COLOR_W'(v[7:0])};
  endfunction

  function automatic logic [COLOR_W-1:0] fadeChan(input logic [COLOR_W-1:0] c,
                                                  input logic [FADE_W-1:0]  f);
    logic [FADE_W:0]   factor;
    logic [PROD_W-1:0] prod;
    factor = (FADE_W + 1)'(2 ** FADE_W) - {1'b0, f};
    prod   = PROD_W'(c) * PROD_W'(factor);
    return COLOR_W'(prod >> FADE_W);
  endfunction

  logic [RGB_W-1:0]   active_q [BANKS][ENTRIES];
  logic [RGB_W-1:0]   shadow_q [BANKS][ENTRIES];

  logic               commit_pending_q, commit_pending_d;
  logic               do_commit;
  logic [FADE_W-1:0]  fade_q, fade_d;
  logic               wr_ok, pix_ok;

  logic               s1_valid_q;
  logic [RGB_W-1:0]   s1_rgb_q, s1_rgb_d;
  logic               rgb_valid_q;
  logic [COLOR_W-1:0] r_q, g_q, b_q;
  logic [COLOR_W-1:0] r_d, g_d, b_d;

  // Stage 1 only reloads on a valid pixel, so r/g/b keep the last colour between pixels
  // while stage 2 still re-applies the current fade every cycle.
  always_comb begin
    wr_ok            = ({1'b0, wr_bank} < BANK_LIMIT);
    pix_ok           = ({1'b0, pix_bank} < BANK_LIMIT);
    do_commit        = frame_start & (commit_pending_q | commit_req);
    commit_pending_d = commit_pending_q;
    if (do_commit) begin
      commit_pending_d = 1'b0;
    end else if (commit_req) begin
      commit_pending_d = 1'b1;
    end
    fade_d   = frame_start ? fade_level : fade_q;
    s1_rgb_d = s1_rgb_q;
    if (pix_valid) begin
      s1_rgb_d = pix_ok ? active_q[pix_bank][pix_index] : '0;
    end
    r_d = fadeChan(s1_rgb_q[3*COLOR_W-1 -: COLOR_W], fade_q);
    g_d = fadeChan(s1_rgb_q[2*COLOR_W-1 -: COLOR_W], fade_q);
    b_d = fadeChan(s1_rgb_q[COLOR_W-1 -: COLOR_W], fade_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int bk = 0; bk < BANKS; bk++) begin
        for (int ix = 0; ix < ENTRIES; ix++) begin
          shadow_q[bk][ix] <= defaultEntry(ix);
        end
      end
    end else if (wr_en && wr_ok) begin
      shadow_q[wr_bank][wr_index] <= wr_rgb;
    end
  end

  // Non-blocking copy takes the shadow as it was before any write on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int bk = 0; bk < BANKS; bk++) begin
        for (int ix = 0; ix < ENTRIES; ix++) begin
          active_q[bk][ix] <= defaultEntry(ix);
        end
      end
    end else if (do_commit) begin
      active_q <= shadow_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_pending_q <= 1'b0;
      fade_q           <= '0;
      s1_valid_q       <= 1'b0;
      s1_rgb_q         <= '0;
      rgb_valid_q      <= 1'b0;
      r_q              <= '0;
      g_q              <= '0;
      b_q              <= '0;
    end else begin
      commit_pending_q <= commit_pending_d;
      fade_q           <= fade_d;
      s1_valid_q       <= pix_valid;
      s1_rgb_q         <= s1_rgb_d;
      rgb_valid_q      <= s1_valid_q;
      r_q              <= r_d;
      g_q              <= g_d;
      b_q              <= b_d;
    end
  end

  assign rgb_valid      = rgb_valid_q;
  assign r              = r_q;
  assign g              = g_q;
  assign b              = b_q;
  assign commit_pending = commit_pending_q;

endmodule

// File: tb/tb_palette_lut.sv
// Directed, table-driven bench for palette_lut: lookups, shadow commit, fade, streaming
// and asynchronous reset, with expected colours written out by hand.
module tb_palette_lut;

  logic        clk;
  logic        reset_n;
  logic        pix_valid;
  logic [1:0]  pix_bank;
  logic [3:0]  pix_index;
  logic        rgb_valid;
  logic [7:0]  r, g, b;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_index;
  logic [23:0] wr_rgb;
  logic        commit_req;
  logic        frame_start;
  logic [2:0]  fade_level;
  logic        commit_pending;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  bank;
    logic [3:0]  idx;
    logic [23:0] rgb;
  } vec_t;

  vec_t        vecs [7];
  logic [23:0] defPal [16];
  logic        sValid [17];
  logic [3:0]  sIdx [17];

  palette_lut dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pix_valid      (pix_valid),
    .pix_bank       (pix_bank),
    .pix_index      (pix_index),
    .rgb_valid      (rgb_valid),
    .r              (r),
    .g              (g),
    .b              (b),
    .wr_en          (wr_en),
    .wr_bank        (wr_bank),
    .wr_index       (wr_index),
    .wr_rgb         (wr_rgb),
    .commit_req     (commit_req),
    .frame_start    (frame_start),
    .fade_level     (fade_level),
    .commit_pending (commit_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] rgb(input int rr, input int gg, input int bb);
    return {8'(rr), 8'(gg), 8'(bb)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] bank, input logic [3:0] idx);
    pix_valid = 1'b1;
    pix_bank  = bank;
    pix_index = idx;
    tick();
    pix_valid = 1'b0;
  endtask

  task automatic lookup(input string name, input logic [1:0] bank, input logic [3:0] idx,
                        input logic [23:0] expRgb);
    applyStimulus(bank, idx);
    tick();
    checkOutput({name, "_valid"}, 32'(rgb_valid), 32'd1);
    checkOutput({name, "_rgb"}, 32'({r, g, b}), 32'(expRgb));
  endtask

  task automatic writeShadow(input logic [1:0] bank, input logic [3:0] idx,
                             input logic [23:0] val);
    wr_en    = 1'b1;
    wr_bank  = bank;
    wr_index = idx;
    wr_rgb   = val;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic frameStart(input logic [2:0] fade, input logic req);
    frame_start = 1'b1;
    fade_level  = fade;
    commit_req  = req;
    tick();
    frame_start = 1'b0;
    commit_req  = 1'b0;
  endtask

  initial begin
    defPal[0]  = rgb(0, 0, 1);       defPal[1]  = rgb(99, 99, 99);
    defPal[2]  = rgb(107, 8, 0);     defPal[3]  = rgb(156, 74, 0);
    defPal[4]  = rgb(173, 173, 173); defPal[5]  = rgb(255, 255, 255);
    defPal[6]  = rgb(90, 0, 123);    defPal[7]  = rgb(181, 49, 33);
    defPal[8]  = rgb(0, 66, 74);     defPal[9]  = rgb(231, 231, 148);
    defPal[10] = rgb(107, 107, 0);   defPal[11] = rgb(231, 156, 33);
    defPal[12] = rgb(181, 247, 206); defPal[13] = rgb(0, 82, 0);
    defPal[14] = rgb(0, 140, 49);    defPal[15] = rgb(0, 0, 0);

    vecs[0] = '{2'd2, 4'd7,  rgb(181, 49, 33)};
    vecs[1] = '{2'd2, 4'd5,  rgb(255, 255, 255)};
    vecs[2] = '{2'd0, 4'd0,  rgb(0, 0, 1)};
    vecs[3] = '{2'd3, 4'd12, rgb(181, 247, 206)};
    vecs[4] = '{2'd1, 4'd9,  rgb(231, 231, 148)};
    vecs[5] = '{2'd0, 4'd15, rgb(0, 0, 0)};
    vecs[6] = '{2'd1, 4'd3,  rgb(156, 74, 0)};

    reset_n = 1'b1; pix_valid = 1'b0; pix_bank = '0; pix_index = '0;
    wr_en = 1'b0; wr_bank = '0; wr_index = '0; wr_rgb = '0;
    commit_req = 1'b0; frame_start = 1'b0; fade_level = '0;
    #2 reset_n = 1'b0;
    tick();
    tick();
    checkOutput("reset_valid", 32'(rgb_valid), 32'd0);
    checkOutput("reset_rgb", 32'({r, g, b}), 32'd0);
    checkOutput("reset_pending", 32'(commit_pending), 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      lookup($sformatf("table%0d", i), vecs[i].bank, vecs[i].idx, vecs[i].rgb);
    end

    // Shadow write is invisible until commit; commit held for 5 cycles until frame_start.
    writeShadow(2'd1, 4'd3, rgb(10, 20, 30));
    lookup("precommit", 2'd1, 4'd3, rgb(156, 74, 0));
    commit_req = 1'b1;
    tick();
    commit_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("pending_held%0d", i), 32'(commit_pending), 32'd1);
      tick();
    end
    checkOutput("pending_before_fs", 32'(commit_pending), 32'd1);
    frame_start = 1'b1;
    pix_valid = 1'b1; pix_bank = 2'd1; pix_index = 4'd3;
    tick();
    frame_start = 1'b0;
    checkOutput("pending_cleared", 32'(commit_pending), 32'd0);
    tick();
    pix_valid = 1'b0;
    checkOutput("fs_cycle_old_rgb", 32'({r, g, b}), 32'(rgb(156, 74, 0)));
    tick();
    checkOutput("after_fs_new_rgb", 32'({r, g, b}), 32'(rgb(10, 20, 30)));
    lookup("committed", 2'd1, 4'd3, rgb(10, 20, 30));
    lookup("other_bank", 2'd0, 4'd3, rgb(156, 74, 0));

    // Write on the commit edge stays in shadow only.
    frame_start = 1'b1; commit_req = 1'b1;
    wr_en = 1'b1; wr_bank = 2'd0; wr_index = 4'd1; wr_rgb = rgb(1, 2, 3);
    tick();
    frame_start = 1'b0; commit_req = 1'b0; wr_en = 1'b0;
    checkOutput("same_cycle_pending", 32'(commit_pending), 32'd0);
    lookup("same_cycle_write", 2'd0, 4'd1, rgb(99, 99, 99));
    frameStart(3'd0, 1'b1);
    lookup("second_commit", 2'd0, 4'd1, rgb(1, 2, 3));

    // Fade, including the old fade applying to the pixel in stage 2 on the frame_start edge.
    frameStart(3'd4, 1'b0);
    lookup("fade4", 2'd2, 4'd7, rgb(90, 24, 16));
    applyStimulus(2'd2, 4'd7);
    frame_start = 1'b1; fade_level = 3'd7;
    tick();
    frame_start = 1'b0;
    checkOutput("fade_edge_valid", 32'(rgb_valid), 32'd1);
    checkOutput("fade_edge_old", 32'({r, g, b}), 32'(rgb(90, 24, 16)));
    tick();
    checkOutput("fade_hold_refade", 32'({r, g, b}), 32'(rgb(22, 6, 4)));
    checkOutput("fade_hold_valid", 32'(rgb_valid), 32'd0);
    lookup("fade7", 2'd2, 4'd7, rgb(22, 6, 4));
    frameStart(3'd0, 1'b0);
    lookup("fade0", 2'd2, 4'd7, rgb(181, 49, 33));

    // Back-to-back stream of 0..15 with one bubble after index 7.
    for (int s = 0; s < 17; s++) begin
      sValid[s] = (s != 8);
      sIdx[s]   = (s < 8) ? 4'(s) : 4'(s - 1);
    end
    for (int c = 0; c <= 17; c++) begin
      if (c < 17) begin
        pix_valid = sValid[c]; pix_bank = 2'd3; pix_index = sIdx[c];
      end else begin
        pix_valid = 1'b0;
      end
      tick();
      if (c >= 1) begin
        checkOutput($sformatf("stream_valid%0d", c - 1), 32'(rgb_valid), 32'(sValid[c - 1]));
        if (sValid[c - 1]) begin
          checkOutput($sformatf("stream_rgb%0d", c - 1), 32'({r, g, b}),
                      32'(defPal[sIdx[c - 1]]));
        end
      end
    end
    pix_valid = 1'b0;
    tick();

    // Asynchronous reset in the middle of a stream after a commit.
    writeShadow(2'd0, 4'd3, rgb(5, 5, 5));
    frameStart(3'd0, 1'b1);
    lookup("pre_reset_commit", 2'd0, 4'd3, rgb(5, 5, 5));
    commit_req = 1'b1;
    pix_valid = 1'b1; pix_bank = 2'd0; pix_index = 4'd3;
    tick();
    commit_req = 1'b0;
    tick();
    checkOutput("pre_reset_valid", 32'(rgb_valid), 32'd1);
    checkOutput("pre_reset_pending", 32'(commit_pending), 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(rgb_valid), 32'd0);
    checkOutput("async_reset_rgb", 32'({r, g, b}), 32'd0);
    checkOutput("async_reset_pending", 32'(commit_pending), 32'd0);
    pix_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    lookup("post_reset_b0", 2'd0, 4'd3, rgb(156, 74, 0));
    lookup("post_reset_b1", 2'd1, 4'd3, rgb(156, 74, 0));
    checkOutput("post_reset_pending", 32'(commit_pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/palette_lut.md
# palette_lut

Banked, run-time-writable colour look-up table with per-frame fade for the sprite/tile pixel path. It sits between the sprite generator (4-bit colour indices) and the VGA output stage and returns 24-bit RGB two cycles after each index. New palette contents are staged in a shadow copy and committed atomically at a frame boundary so a frame never shows a half-written palette. A global fade level scales all outputs for screen transitions.

## Interface
- INDEX_W, 4, colour-index width; entries per bank = 2**INDEX_W
- BANKS, 4, number of palette banks; BANK_W = max(1, $clog2(BANKS))
- COLOR_W, 8, bits per colour channel
- FADE_W, 3, fade-level width
- clk  in  1  single clock; all logic is on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- pix_valid  in  1  index valid this cycle
- pix_bank  in  BANK_W  palette bank for this pixel
- pix_index  in  INDEX_W  colour index
- rgb_valid  out  1  pix_valid delayed 2 cycles
- r, g, b  out  COLOR_W each  faded colour
- wr_en  in  1  write one shadow entry
- wr_bank  in  BANK_W  shadow bank to write
- wr_index  in  INDEX_W  shadow entry to write
- wr_rgb  in  3*COLOR_W  {R,G,B}, R in MSBs
- commit_req  in  1  pulse: request shadow→active copy at next frame_start
- frame_start  in  1  one-cycle pulse at start of vertical blank
- fade_level  in  FADE_W  0 = full brightness; sampled at frame_start
- commit_pending  out  1  commit requested, not yet performed

## Operation
- Storage: active[BANKS][2**INDEX_W] and shadow[BANKS][2**INDEX_W] registers; pixel lookups read only active, writes touch only shadow.
- Reset: every bank of active and shadow loads the default palette, indices 0..15: (0,0,1) (99,99,99) (107,8,0) (156,74,0) (173,173,173) (255,255,255) (90,0,123) (181,49,33) (0,66,74) (231,231,148) (107,107,0) (231,156,33) (181,247,206) (0,82,0) (0,140,49) (0,0,0). Entries ≥16 reset to 0. If COLOR_W≠8, the value is zero-extended or truncated keeping LSBs. commit_pending=0, latched fade=0, rgb_valid=0, r=g=b=0, pipeline valids=0.
- Write: wr_en=1 writes wr_rgb to shadow[wr_bank][wr_index] at the clock edge. wr_bank ≥ BANKS → write ignored.
- Commit: commit_req sets commit_pending. On frame_start with (commit_pending | commit_req), all of active ← shadow in that edge, commit_pending ← 0. The copy uses shadow contents before this cycle's write; a same-cycle write stays in shadow only. A commit_req with no frame_start is held until the next frame_start.
- Fade: frame_start latches fade_level into fade_q. Each channel out = (c × (2**FADE_W − fade_q)) >> FADE_W, floored, computed at (COLOR_W+FADE_W+1) bits. fade_q=0 gives c exactly.
- Lookup with pix_bank ≥ BANKS returns 0 for all channels, rgb_valid still asserted.

## Timing
- Stage 1 (edge N): register active[pix_bank][pix_index] and pix_valid.
- Stage 2 (edge N+1): apply fade_q and register r/g/b/rgb_valid. Latency is exactly 2 cycles, throughput 1 pixel/cycle, no stall.
- r/g/b hold the last computed value when rgb_valid=0. Stage 2 computes every cycle regardless of valid.
- Lookups sampled on the frame_start cycle read pre-commit active. Lookups from the next cycle on see the new active.
- The fade value latched at frame_start applies to stage-2 outputs from edge frame_start+1 onward. A pixel in stage 2 on that edge uses the old fade.
- reset_n assertion mid-frame clears the pipeline immediately (asynchronous). Pixels in flight are dropped and both tables revert to the default palette.

## Test plan
- Reset, then pix_index 7 bank 2 with pix_valid=1 → two cycles later rgb_valid=1, (181,49,33). Index 5 → (255,255,255).
- Write shadow bank 1 index 3 = (10,20,30), no commit → lookup returns (156,74,0). Then commit_req, with frame_start 5 cycles later → commit_pending is 1 until that edge. Lookups issued after frame_start return (10,20,30); bank 0 index 3 stays (156,74,0).
- Same cycle: frame_start, commit_req, and wr_en to bank 0 index 1 = (1,2,3) → active bank 0 index 1 stays (99,99,99). A second commit at the next frame_start makes it (1,2,3).
- fade_level=4 latched at frame_start, index 7 → (90,24,16). fade_level=7 → (22,6,4). fade_level=0 → exact (181,49,33).
- Streaming indices 0..15 back-to-back with pix_valid=1 → 16 consecutive rgb_valid cycles in order. A bubble in pix_valid gives a bubble in rgb_valid 2 cycles later.
- Drive reset_n low mid-stream after a commit → outputs zero and rgb_valid=0 asynchronously. After release, index 3 returns (156,74,0) and commit_pending=0.
